ieee_float_to_dec: RTL
======================

Name: ieee_float_to_dec

Overview:
Iterative converter from IEEE754 single precision to the team's split-decimal format: signed integer part (lhs_dec) plus fractional digits as an unsigned decimal integer (rhs_dec). It is the reverse path of the decimal-to-float converter and sits after the fp adder, so results can be read back as decimal. A start/busy/done handshake wraps a multi-cycle FSM that emits one fractional digit per cycle.

Parameters:
FRAC_DIGITS, 4, number of fractional decimal digits produced; legal range 1..9.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
flt  input  32  IEEE754 operand; captured on the accepting edge
busy  output  1  high whenever FSM is not IDLE
done  output  1  one-cycle pulse; result valid
lhs_dec  output  32  two's-complement integer part (truncated toward zero)
rhs_dec  output  32  floor(|frac| * 10^FRAC_DIGITS), unsigned
neg  output  1  sign bit of flt
ovf  output  1  |value| >= 2^31
inv  output  1  input exponent == 255 (Inf/NaN)

Behaviour:
- Reset (async): state=IDLE; busy, done, neg, ovf, inv = 0; lhs_dec = rhs_dec = 0.
- States: IDLE -> DECODE (1 cycle) -> DIGIT (FRAC_DIGITS cycles, down-counter) -> DONE (1 cycle) -> IDLE.
- Start: if start=1 in IDLE at edge k, flt is latched and the FSM moves to DECODE. lhs/rhs/flags update and done rises after edge k+FRAC_DIGITS+1, so latency is FRAC_DIGITS+1 cycles.
- start in DECODE, DIGIT or DONE is ignored; no queueing. The next start is accepted in the cycle after done.
- Outputs hold their last result until the next done.
- DECODE: e = exp-127; m = {1, mantissa}, 24 bits.
  - Integer magnitude: m>>(23-e) for 0<=e<=23; m<<(e-23) for 24<=e<=30; 0 for e<0.
  - Fraction frac32: the bits of m below the binary point, left-aligned in 32 bits. Bits below 2^-32 are truncated.
- DIGIT step: p = frac32*10 (36 bits); digit = p[35:32]; frac32 = p[31:0]; acc = acc*10 + digit, MSB digit first.
- DONE:
  - rhs_dec = acc.
  - lhs_dec = neg ? -int : int.
  - neg = flt[31].
- exp==0 (zero or denormal): flushed to zero. lhs = rhs = 0, neg = sign bit, ovf = inv = 0.
- exp==255: inv=1, lhs = rhs = 0, ovf = 0, neg = sign bit.
- e>=31: ovf=1. lhs saturates to 0x7FFFFFFF (positive) or 0x80000000 (negative); rhs=0. This includes exactly -2^31.
- For these special cases the FSM still walks every state, so latency is constant.
- Reset mid-operation aborts with no done pulse, and outputs return to reset values.

Optional Feature:
TRIM_ZEROS_EN.
- Defined: rhs_dec has trailing zero digits removed, matching the forward converter's fraction format (0.5 -> 5, 0.375 -> 375, zero fraction -> 0). Implemented by snapshotting acc at each nonzero digit, with no divider; latency is unchanged.
- Undefined: rhs_dec is fixed-width (0.5 -> 5000 for FRAC_DIGITS=4).

Decomposition:
- Package fc_float_pkg holds:
  - constants: EXP_W=8, MAN_W=23, BIAS=127, EXP_SPECIAL=8'hFF;
  - the state enum type (IDLE, DECODE, DIGIT, DONE);
  - the saturation constants 32'h7FFFFFFF and 32'h80000000.
- One sub-module, fc_frac_digit_step: a combinational x10 step taking frac32 in and returning the digit[3:0] and the next frac32. It is instantiated once and reused every DIGIT cycle.

Test Plan:
- flt=0x40490FDB (3.14159274), FRAC_DIGITS=4 -> after 5 cycles: lhs=3, rhs=1415, neg=0, ovf=inv=0. done is high for exactly one cycle.
- flt=0xC1260000 (-10.375) -> lhs=0xFFFFFFF6, rhs=3750 (375 with TRIM_ZEROS_EN), neg=1.
- flt=0xBF000000 (-0.5) -> lhs=0, neg=1, rhs=5000 (5 with TRIM_ZEROS_EN).
- flt=0x4F000000 -> ovf=1, lhs=0x7FFFFFFF, rhs=0. flt=0x7FC00000 -> inv=1, lhs=rhs=0. flt=0x00000001 -> all zero.
- start pulsed again during DIGIT with a different flt -> ignored; the first result is unchanged. A start in the cycle after done is accepted.
- reset asserted during DIGIT -> outputs go to 0 immediately (async), no done pulse. A new start after reset is released converts correctly.

Source files
------------

// File: rtl/fc_float_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fc_float_pkg
// Purpose : Shared constants and types for the IEEE754-single to
//           split-decimal converter (ieee_float_to_dec).
//           - IEEE754 single field widths, bias and special exponent
//           - saturation values for out-of-range integer parts
//           - FSM state and operand class enumerations
// Revision: 1.0 - initial release
// ============================================================================
package fc_float_pkg;

    localparam int          EXP_W       = 8;
    localparam int          MAN_W       = 23;
    localparam int          BIAS        = 127;
    localparam logic [7:0]  EXP_SPECIAL = 8'hFF;

    localparam logic [31:0] SAT_POS     = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_NEG     = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        DIGIT  = 2'd2,
        DONE   = 2'd3
    } fc_state_e;

    // Operand class decided in DECODE and applied when results are written.
    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INV  = 2'd2,
        CLS_OVF  = 2'd3
    } fc_class_e;

endpackage
`default_nettype wire

// File: rtl/fc_frac_digit_step.sv
`default_nettype none
// ============================================================================
// Module  : fc_frac_digit_step
// Purpose : One decimal digit extraction step on a 32-bit binary fraction.
//           The fraction is multiplied by ten; the four bits that spill above
//           the binary point are the next decimal digit, the low 32 bits are
//           the remaining fraction.
// Ports   : i_frac  [31:0] fraction in, weight of bit 31 is 2^-1
//           o_digit [3:0]  decimal digit 0..9
//           o_frac  [31:0] remaining fraction
// Revision: 1.0 - initial release
// ============================================================================
module fc_frac_digit_step (
    input  logic [31:0] i_frac,
    output logic [3:0]  o_digit,
    output logic [31:0] o_frac
);

    logic [35:0] w_prod;

    // x10 as x8 + x2, kept at 36 bits so the integer digit is not lost.
    assign w_prod  = ({4'b0, i_frac} << 3) + ({4'b0, i_frac} << 1);
    assign o_digit = w_prod[35:32];
    assign o_frac  = w_prod[31:0];

endmodule
`default_nettype wire

// File: rtl/ieee_float_to_dec.sv
`default_nettype none
// ============================================================================
// Module  : ieee_float_to_dec
// Purpose : Iterative IEEE754 single precision to split-decimal converter.
//           Produces a signed integer part and FRAC_DIGITS fractional decimal
//           digits (one per cycle) behind a start/busy/done handshake.
//           Latency from the accepting edge is FRAC_DIGITS+1 cycles, constant
//           for every operand class.
// Ports   : clk, reset (async, active-high)
//           start, flt[31:0]       request and operand (sampled in IDLE)
//           busy, done             status, done is a one-cycle pulse
//           lhs_dec[31:0]          two's-complement integer part
//           rhs_dec[31:0]          fractional digits as unsigned integer
//           neg, ovf, inv          sign, |value|>=2^31, Inf/NaN
// Config  : TRIM_ZEROS_EN - when defined, trailing zero digits are removed
//           from rhs_dec (0.5 -> 5 instead of 5000).
// Revision: 1.0 - initial release
// ============================================================================
module ieee_float_to_dec
    import fc_float_pkg::*;
#(
    parameter int FRAC_DIGITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] flt,
    output logic        busy,
    output logic        done,
    output logic [31:0] lhs_dec,
    output logic [31:0] rhs_dec,
    output logic        neg,
    output logic        ovf,
    output logic        inv
);

    localparam int CNT_W = 4;

    fc_state_e          state_q, state_d;
    fc_class_e          cls_q,   cls_d;
    logic [31:0]        flt_q,   flt_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [31:0]        int_q,   int_d;
    logic [31:0]        frac_q,  frac_d;
    logic [31:0]        acc_q,   acc_d;
    logic [31:0]        trim_q,  trim_d;
    logic [31:0]        lhs_q,   lhs_d;
    logic [31:0]        rhs_q,   rhs_d;
    logic               neg_q,   neg_d;
    logic               ovf_q,   ovf_d;
    logic               inv_q,   inv_d;

    // ---------------- decode datapath ----------------
    logic [EXP_W-1:0]   w_exp;
    logic [MAN_W:0]     w_man;
    logic [7:0]         w_rsh;
    logic [63:0]        w_fix;
    logic [31:0]        w_big;

    assign w_exp = flt_q[30:23];
    assign w_man = {1'b1, flt_q[MAN_W-1:0]};

    // Fixed point with 32 fraction bits: value*2^32 = m << (e+9) = (m<<40) >> (31-e).
    // 31-e = (BIAS+31) - exp, valid for exp <= BIAS+23; larger shifts give 0.
    assign w_rsh = 8'(BIAS + 31) - w_exp;
    assign w_fix = {w_man, 40'b0} >> w_rsh;
    // Integer-only range 24 <= e <= 30: shift left by e-23.
    assign w_big = {8'b0, w_man} << (w_exp - 8'(BIAS + 23));

    // ---------------- digit datapath ----------------
    logic [3:0]         w_digit;
    logic [31:0]        w_frac_next;
    logic [31:0]        w_acc_next;
    logic [31:0]        w_rhs_final;

    fc_frac_digit_step u_step (
        .i_frac  (frac_q),
        .o_digit (w_digit),
        .o_frac  (w_frac_next)
    );

    assign w_acc_next = (acc_q << 3) + (acc_q << 1) + {28'b0, w_digit};

`ifdef TRIM_ZEROS_EN
    // trim_q holds acc as of the last nonzero digit, i.e. acc without the
    // trailing zeros seen so far.
    assign w_rhs_final = (w_digit != 4'd0) ? w_acc_next : trim_q;
`else
    assign w_rhs_final = w_acc_next;
`endif

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        flt_d   = flt_q;
        cnt_d   = cnt_q;
        int_d   = int_q;
        frac_d  = frac_q;
        acc_d   = acc_q;
        trim_d  = trim_q;
        lhs_d   = lhs_q;
        rhs_d   = rhs_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        inv_d   = inv_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    flt_d   = flt;
                    state_d = DECODE;
                end
            end

            DECODE: begin
                cnt_d   = CNT_W'(FRAC_DIGITS);
                acc_d   = 32'd0;
                trim_d  = 32'd0;
                int_d   = 32'd0;
                frac_d  = 32'd0;
                cls_d   = CLS_NORM;
                if (w_exp == 8'd0) begin
                    cls_d = CLS_ZERO;
                end else if (w_exp == EXP_SPECIAL) begin
                    cls_d = CLS_INV;
                end else if (w_exp >= 8'(BIAS + 31)) begin
                    cls_d = CLS_OVF;
                end else if (w_exp >= 8'(BIAS + 24)) begin
                    int_d = w_big;
                end else begin
                    int_d  = w_fix[63:32];
                    frac_d = w_fix[31:0];
                end
                state_d = DIGIT;
            end

            DIGIT: begin
                frac_d = w_frac_next;
                acc_d  = w_acc_next;
                if (w_digit != 4'd0) begin
                    trim_d = w_acc_next;
                end
                cnt_d = cnt_q - CNT_W'(1);
                // Results are written on the last digit edge so they are
                // presented together with done.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    neg_d   = flt_q[31];
                    ovf_d   = 1'b0;
                    inv_d   = 1'b0;
                    lhs_d   = 32'd0;
                    rhs_d   = 32'd0;
                    case (cls_q)
                        CLS_INV:  inv_d = 1'b1;
                        CLS_OVF: begin
                            ovf_d = 1'b1;
                            lhs_d = flt_q[31] ? SAT_NEG : SAT_POS;
                        end
                        CLS_NORM: begin
                            lhs_d = flt_q[31] ? (-int_q) : int_q;
                            rhs_d = w_rhs_final;
                        end
                        default: ;
                    endcase
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cls_q   <= CLS_NORM;
            flt_q   <= 32'd0;
            cnt_q   <= '0;
            int_q   <= 32'd0;
            frac_q  <= 32'd0;
            acc_q   <= 32'd0;
            trim_q  <= 32'd0;
            lhs_q   <= 32'd0;
            rhs_q   <= 32'd0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            flt_q   <= flt_d;
            cnt_q   <= cnt_d;
            int_q   <= int_d;
            frac_q  <= frac_d;
            acc_q   <= acc_d;
            trim_q  <= trim_d;
            lhs_q   <= lhs_d;
            rhs_q   <= rhs_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            inv_q   <= inv_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign lhs_dec = lhs_q;
    assign rhs_dec = rhs_q;
    assign neg     = neg_q;
    assign ovf     = ovf_q;
    assign inv     = inv_q;

endmodule
`default_nettype wire
